// File: rtl/regfile_tagged_mp_if.sv
// rtl/regfile_tagged_mp_if.sv - issue/CDB/read bundle for the tagged register file
interface regfile_tagged_mp_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int TAG_W    = 4
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic                     alloc_valid;
    logic [AW-1:0]            alloc_addr;
    logic [TAG_W-1:0]         alloc_tag;
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR*TAG_W-1:0]  wr_tag;
    logic [NUM_WR*XLEN-1:0]   wr_data;
    logic                     flush;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_RD*TAG_W-1:0]  rd_tag;
    logic [CW-1:0]            busy_count;

    modport master (
        output alloc_valid, alloc_addr, alloc_tag, wr_valid, wr_tag, wr_data, flush, rd_addr,
        input  rd_data, rd_busy, rd_tag, busy_count
    );
    modport slave (
        input  alloc_valid, alloc_addr, alloc_tag, wr_valid, wr_tag, wr_data, flush, rd_addr,
        output rd_data, rd_busy, rd_tag, busy_count
    );
endinterface

// File: rtl/regfile_tagged_mp.sv
// rtl/regfile_tagged_mp.sv - multi-port register file with busy/tag tracking and CDB writeback
module regfile_tagged_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int TAG_W    = 4,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_tagged_mp_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0][XLEN-1:0]  data_q, data_d;
    logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NUM_REGS-1:0]            busy_q, busy_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [NUM_REGS-1:0]            hit;
    logic [NUM_REGS-1:0][XLEN-1:0]  hit_data;

    // Ports scanned high to low so the lowest matching port is the one that sticks.
    always_comb begin
        hit      = '0;
        hit_data = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int i = NUM_WR - 1; i >= 0; i--) begin
                if (busy_q[r] && bus.wr_valid[i] && bus.wr_tag[i*TAG_W +: TAG_W] == tag_q[r]) begin
                    hit[r]      = 1'b1;
                    hit_data[r] = bus.wr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        count_d = '0;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (hit[r]) begin
                    data_d[r] = hit_data[r];
                    busy_d[r] = 1'b0;
                end
                // A same-cycle alloc overrides the completion's busy clear.
                if (bus.alloc_valid && bus.alloc_addr == AW'(r)) begin
                    busy_d[r] = 1'b1;
                    tag_d[r]  = bus.alloc_tag;
                end
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + CW'(busy_d[r]);
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        a           = '0;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.rd_tag  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            if (a != '0) begin
                bus.rd_tag[p*TAG_W +: TAG_W] = tag_q[a];
                if (BYPASS != 0 && !bus.flush && hit[a]) begin
                    bus.rd_data[p*XLEN +: XLEN] = hit_data[a];
                    bus.rd_busy[p]              = 1'b0;
                end else begin
                    bus.rd_data[p*XLEN +: XLEN] = data_q[a];
                    bus.rd_busy[p]              = busy_q[a];
                end
            end
        end
    end

    assign bus.busy_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            tag_q   <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_regfile_tagged_mp.sv
// tb/tb_regfile_tagged_mp.sv - scoreboard bench for regfile_tagged_mp, bypass and no-bypass instances
module tb_regfile_tagged_mp;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int TW   = 4;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_tagged_mp_if #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW)) bus1 ();
    regfile_tagged_mp_if #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW)) bus0 ();

    regfile_tagged_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW), .BYPASS(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    regfile_tagged_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW), .BYPASS(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    typedef struct {
        logic [NRD*XLEN-1:0] d1, d0;
        logic [NRD-1:0]      b1, b0;
        logic [NRD*TW-1:0]   t1, t0;
        logic [CW-1:0]       c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [XLEN-1:0] m_data [NR];
    logic [TW-1:0]   m_tag  [NR];
    bit              m_busy [NR];

    bit              c_rst, c_av, c_fl;
    logic [AW-1:0]   c_aa;
    logic [TW-1:0]   c_at;
    logic [NWR-1:0]  c_wv;
    logic [TW-1:0]   c_wt [NWR];
    logic [XLEN-1:0] c_wd [NWR];
    logic [AW-1:0]   c_ra [NRD];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Lowest CDB port whose tag completes register r this cycle, or -1.
    function automatic int port_hit(input int r);
        if (r == 0 || !m_busy[r]) return -1;
        for (int i = 0; i < NWR; i++)
            if (c_wv[i] && c_wt[i] == m_tag[r]) return i;
        return -1;
    endfunction

    task automatic drive(input bit rst, input bit av, input int aa, input int at,
                         input logic [1:0] wv, input int wt0, input logic [31:0] wd0,
                         input int wt1, input logic [31:0] wd1, input bit fl,
                         input int ra0, input int ra1);
        exp_t e;
        int   n;
        c_rst = rst; c_av = av; c_aa = AW'(aa); c_at = TW'(at); c_wv = wv; c_fl = fl;
        c_wt[0] = TW'(wt0); c_wt[1] = TW'(wt1); c_wd[0] = wd0; c_wd[1] = wd1;
        c_ra[0] = AW'(ra0); c_ra[1] = AW'(ra1);
        rst_n = rst;
        if (!rst) begin
            for (int r = 0; r < NR; r++) begin
                m_data[r] = '0; m_tag[r] = '0; m_busy[r] = 0;
            end
        end
        bus1.alloc_valid = av;   bus0.alloc_valid = av;
        bus1.alloc_addr  = c_aa; bus0.alloc_addr  = c_aa;
        bus1.alloc_tag   = c_at; bus0.alloc_tag   = c_at;
        bus1.wr_valid    = wv;   bus0.wr_valid    = wv;
        bus1.wr_tag      = {c_wt[1], c_wt[0]}; bus0.wr_tag  = {c_wt[1], c_wt[0]};
        bus1.wr_data     = {wd1, wd0};         bus0.wr_data = {wd1, wd0};
        bus1.flush       = fl;   bus0.flush       = fl;
        bus1.rd_addr     = {c_ra[1], c_ra[0]}; bus0.rd_addr = {c_ra[1], c_ra[0]};
        for (int p = 0; p < NRD; p++) begin
            int a, h;
            logic [XLEN-1:0] d;
            logic [TW-1:0]   t;
            bit              b;
            a = int'(c_ra[p]);
            h = port_hit(a);
            d = (a == 0) ? '0 : m_data[a];
            t = (a == 0) ? '0 : m_tag[a];
            b = (a == 0) ? 0  : m_busy[a];
            e.d0[p*XLEN +: XLEN] = d;
            e.b0[p]              = b;
            e.t0[p*TW +: TW]     = t;
            e.d1[p*XLEN +: XLEN] = (h >= 0 && !fl) ? c_wd[h] : d;
            e.b1[p]              = (h >= 0 && !fl) ? 1'b0 : b;
            e.t1[p*TW +: TW]     = t;
        end
        n = 0;
        for (int r = 0; r < NR; r++) n += m_busy[r] ? 1 : 0;
        e.c = CW'(n);
        exp_q.push_back(e);
    endtask

    task automatic step();
        int h [NR];
        @(posedge clk);
        if (c_rst) begin
            for (int r = 0; r < NR; r++) h[r] = port_hit(r);
            for (int r = 1; r < NR; r++) begin
                if (c_fl) begin
                    m_busy[r] = 0;
                end else begin
                    if (h[r] >= 0) begin
                        m_data[r] = c_wd[h[r]];
                        m_busy[r] = 0;
                    end
                    if (c_av && int'(c_aa) == r) begin
                        m_busy[r] = 1;
                        m_tag[r]  = c_at;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int ra0, input int ra1);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_data_bp",    64'(bus1.rd_data),    64'(e.d1));
            check("rd_busy_bp",    64'(bus1.rd_busy),    64'(e.b1));
            check("rd_tag_bp",     64'(bus1.rd_tag),     64'(e.t1));
            check("busy_count_bp", 64'(bus1.busy_count), 64'(e.c));
            check("rd_data_nbp",   64'(bus0.rd_data),    64'(e.d0));
            check("rd_busy_nbp",   64'(bus0.rd_busy),    64'(e.b0));
            check("rd_tag_nbp",    64'(bus0.rd_tag),     64'(e.t0));
            check("busy_count_nbp", 64'(bus0.busy_count), 64'(e.c));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0); step();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5, 1); step();
        idle(3, 31); #1;
        check("reset_count", 64'(bus1.busy_count), 64'd0);
        check("reset_rd",    64'(bus1.rd_data),    64'd0);
        step();

        // Alloc x3 tag 7, then complete it on port 1 while reading x3.
        drive(1, 1, 3, 7, 2'b00, 0, 0, 0, 0, 0, 3, 0); step();
        drive(1, 0, 0, 0, 2'b10, 0, 0, 7, 32'hDEADBEEF, 0, 3, 0); #1;
        check("bypass_data",  64'(bus1.rd_data[31:0]), 64'hDEADBEEF);
        check("bypass_busy",  64'(bus1.rd_busy[0]),    64'd0);
        check("nobypass_busy", 64'(bus0.rd_busy[0]),   64'd1);
        step();
        idle(3, 0); #1;
        check("x3_reg_data", 64'(bus0.rd_data[31:0]), 64'hDEADBEEF);
        check("x3_count",    64'(bus1.busy_count),    64'd0);
        step();

        // Stale completion on a re-allocated register.
        drive(1, 1, 4, 2, 2'b00, 0, 0, 0, 0, 0, 4, 0); step();
        drive(1, 1, 4, 5, 2'b00, 0, 0, 0, 0, 0, 4, 0); step();
        drive(1, 0, 0, 0, 2'b01, 2, 32'h11, 0, 0, 0, 4, 0); step();
        idle(4, 0); #1;
        check("stale_busy", 64'(bus1.rd_busy[0]),  64'd1);
        check("stale_tag",  64'(bus1.rd_tag[3:0]), 64'd5);
        step();
        drive(1, 0, 0, 0, 2'b01, 5, 32'h22, 0, 0, 0, 4, 0); step();
        idle(4, 0); #1;
        check("stale_done", 64'(bus0.rd_data[31:0]), 64'h22);
        step();

        // Completion and re-alloc of x6 in the same cycle.
        drive(1, 1, 6, 1, 2'b00, 0, 0, 0, 0, 0, 6, 0); step();
        drive(1, 1, 6, 9, 2'b01, 1, 32'h55, 0, 0, 0, 6, 0); #1;
        check("coll_bp_data", 64'(bus1.rd_data[31:0]), 64'h55);
        check("coll_bp_busy", 64'(bus1.rd_busy[0]),    64'd0);
        step();
        idle(0, 6); #1;
        check("coll_data", 64'(bus0.rd_data[63:32]), 64'h55);
        check("coll_busy", 64'(bus0.rd_busy[1]),      64'd1);
        check("coll_tag",  64'(bus0.rd_tag[7:4]),     64'd9);
        step();

        // x0 alloc ignored; dual CDB completes x8 and x9 together.
        drive(1, 1, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 6); step();
        drive(1, 1, 8, 10, 2'b00, 0, 0, 0, 0, 0, 0, 8); step();
        drive(1, 1, 9, 11, 2'b00, 0, 0, 0, 0, 0, 8, 9); step();
        idle(8, 9); #1;
        check("dual_pre_count", 64'(bus1.busy_count), 64'd3);
        step();
        drive(1, 0, 0, 0, 2'b11, 10, 32'hA8, 11, 32'hA9, 0, 8, 9); step();
        idle(8, 9); #1;
        check("dual_count", 64'(bus1.busy_count), 64'd1);
        check("dual_data",  64'(bus0.rd_data),    {32'hA9, 32'hA8});
        step();

        // Flush with a concurrent matching completion.
        drive(1, 1, 10, 12, 2'b00, 0, 0, 0, 0, 0, 10, 0); step();
        drive(1, 1, 11, 13, 2'b00, 0, 0, 0, 0, 0, 11, 0); step();
        drive(1, 0, 0, 0, 2'b01, 12, 32'h99, 0, 0, 1, 10, 11); #1;
        check("flush_pre_count", 64'(bus1.busy_count),  64'd3);
        check("flush_no_bypass", 64'(bus1.rd_busy[0]),  64'd1);
        step();
        idle(10, 6); #1;
        check("flush_count", 64'(bus1.busy_count),    64'd0);
        check("flush_data",  64'(bus1.rd_data[31:0]), 64'd0);
        step();

        // Asynchronous reset mid-run with x5 busy.
        drive(1, 1, 5, 4, 2'b00, 0, 0, 0, 0, 0, 5, 0); step();
        drive(1, 0, 0, 0, 2'b01, 4, 32'h77, 0, 0, 0, 5, 0); step();
        drive(1, 1, 5, 6, 2'b00, 0, 0, 0, 0, 0, 5, 0); step();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5, 3); #1;
        check("mid_reset_data",  64'(bus1.rd_data[31:0]), 64'd0);
        check("mid_reset_busy",  64'(bus1.rd_busy[0]),    64'd0);
        check("mid_reset_count", 64'(bus1.busy_count),    64'd0);
        step();
        idle(5, 3); step();

        for (int n = 0; n < 600; n++) begin
            int wt0, wt1, ra0, ra1;
            wt0 = ($urandom_range(0, 3) != 0) ? int'(m_tag[$urandom_range(1, NR-1)]) : int'($urandom_range(0, 15));
            wt1 = ($urandom_range(0, 3) != 0) ? int'(m_tag[$urandom_range(1, NR-1)]) : int'($urandom_range(0, 15));
            ra0 = int'($urandom_range(0, NR-1));
            ra1 = ($urandom_range(0, 1) != 0) ? int'(c_aa) : int'($urandom_range(0, NR-1));
            drive($urandom_range(0, 149) != 0, $urandom_range(0, 1) != 0,
                  int'($urandom_range(0, NR-1)), int'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), wt0, $urandom, wt1, $urandom,
                  $urandom_range(0, 24) == 0, ra0, ra1);
            step();
        end
        idle(0, 0); step();
        @(negedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_tagged_mp.md
Name: regfile_tagged_mp

Overview:
- Parametrised multi-port register file with per-register busy/tag tracking; successor to the single-write, dual-read integer regfile.
- Sits between the issue stage and the CDB. Issue allocates destination tags. CDB broadcasts write results by tag match, not by address, so stale completions are discarded.
- Read ports return value, busy flag and pending tag, with optional same-cycle CDB bypass.
- Flush clears all busy state; a registered busy counter reports how many registers are busy.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, register count; must be a power of 2, ≥2.
- NUM_RD, 2, read ports.
- NUM_WR, 2, CDB write ports.
- TAG_W, 4, tag width.
- BYPASS, 1, 1 = same-cycle CDB forwarding on reads; 0 = reads see registered state only.
- Derived: AW = $clog2(NUM_REGS); CW = $clog2(NUM_REGS+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- alloc_valid  in  1  allocate a destination this cycle.
- alloc_addr  in  AW  destination register.
- alloc_tag  in  TAG_W  tag assigned to that destination.
- wr_valid  in  NUM_WR  per-port CDB valid.
- wr_tag  in  NUM_WR*TAG_W  per-port CDB tag; port i in bits [i*TAG_W +: TAG_W].
- wr_data  in  NUM_WR*XLEN  per-port CDB data.
- flush  in  1  clear all busy bits.
- rd_addr  in  NUM_RD*AW  read addresses.
- rd_data  out  NUM_RD*XLEN  read values.
- rd_busy  out  NUM_RD  read register still pending.
- rd_tag  out  NUM_RD*TAG_W  pending tag of the read register.
- busy_count  out  CW  registered count of busy registers.

Behaviour:
State and reset:
- Per register r: data[r] (XLEN), busy[r], tag[r] (TAG_W).
- rst_n low, asynchronously: all data, busy, tag and busy_count go to 0. Read outputs are therefore 0 while in reset.
- Register 0 is hardwired: reads give data 0, busy 0, tag 0. Alloc to register 0 and CDB matches on register 0 are ignored.

CDB write, per register r != 0:
- Matches when busy[r]=1, wr_valid[i]=1 and wr_tag[i]==tag[r].
- On a match, next data[r]=wr_data[i] and next busy[r]=0.
- Multiple matching ports in one cycle is a protocol violation; the lowest index i wins.
- Tags matching no busy register are dropped silently.

Allocation:
- alloc_valid with alloc_addr != 0: next busy=1 and next tag=alloc_tag for that register.
- Alloc and CDB match on the same register in the same cycle:
  - data takes the CDB value;
  - busy stays 1 and tag becomes alloc_tag (alloc wins).

Flush:
- Next cycle every busy=0. data and tag are retained.
- In the flush cycle, alloc and all CDB writes are ignored entirely; no data update.

Reads (combinational):
- Reads see pre-edge state and never reflect a same-cycle alloc, so an instruction reading its own destination gets the old value and old busy/tag.
- rd_addr==0: data 0, busy 0, tag 0.
- Otherwise, when BYPASS=1, busy[r]=1 and a CDB port matches tag[r] this cycle: rd_data=wr_data (lowest matching port), rd_busy=0, rd_tag=tag[r].
- Otherwise: data[r], busy[r], tag[r].
- Bypass is suppressed when flush=1.

busy_count:
- Registered popcount of busy after each edge.
- Valid the cycle after any change; 0 the cycle after flush or reset.
- Never exceeds NUM_REGS-1.

Latency:
- Alloc is visible on reads the cycle after.
- CDB data is visible the same cycle with BYPASS=1, otherwise the next cycle.

Test Plan:
- Reset: rst_n low mid-run with x5 busy → immediately rd_data/rd_busy of x5 read 0 and busy_count=0; after release all reads are 0.
- Alloc and bypass: alloc x3 tag 7; next cycle CDB port1 tag 7 data 0xDEADBEEF while reading x3 → same cycle rd_data=0xDEADBEEF, rd_busy=0; next cycle registered value 0xDEADBEEF, busy_count back to 0.
- Stale tag: alloc x4 tag 2, then re-alloc x4 tag 5; CDB tag 2 data 0x11 → x4 unchanged, busy=1, tag=5; CDB tag 5 data 0x22 → x4=0x22.
- Same-cycle collision: x6 busy tag 1; in one cycle CDB tag 1 data 0x55 plus alloc x6 tag 9 → next cycle data 0x55, busy=1, tag 9. A read of x6 in that cycle returns 0x55 with busy 0 (bypass).
- x0 and dual CDB: alloc x0 → no effect; CDB ports 0 and 1 write distinct tags to x8 and x9 in one cycle → both update and busy_count drops by 2.
- Flush: three registers busy (busy_count=3), assert flush with a concurrent matching CDB write → next cycle busy_count=0 and data unchanged; repeat with BYPASS=0 → no forwarding on any read.
